apb_uart_regfile: RTL
=====================

APB_UART_REGFILE -- requirements
Module: apb_uart_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 8, register and data width (8..32).
REQ-002 SHALL have parameter ADDR_W, default 3, word-address width; 2**ADDR_W register slots.
REQ-003 SHALL have parameter WAIT_STATES, default 0, extra pready-low cycles per access (0..3).
REQ-004 SHALL have ports: pclk in 1 APB clock; presetn in 1 reset, asynchronous, active-low.
REQ-005 SHALL have ports: psel in 1; penable in 1; pwrite in 1; paddr in ADDR_W word address; pwdata in DATA_W.
REQ-006 SHALL have ports: prdata out DATA_W; pready out 1; pslverr out 1.
REQ-007 SHALL have ports: baud_val out 2*DATA_W {BAUD_HI,BAUD_LO}; ctrl out DATA_W; tx_data out DATA_W; tx_wr out 1 one-cycle write strobe.
REQ-008 SHALL have ports: tx_full in 1; rx_data in DATA_W; rx_valid in 1; rx_rd out 1 one-cycle read strobe; irq out 1.

Function
REQ-009 SHALL sample all inputs and update all registers on the rising edge of pclk only.
REQ-010 SHALL implement the register map: 0 BAUD_LO RW; 1 BAUD_HI RW; 2 TXDATA WO; 3 RXDATA RO; 4 STATUS RO; 5 CTRL RW; 6 and up reserved.
REQ-011 SHALL set STATUS as follows: bit0 tx_rdy = ~tx_full; bit1 rx_rdy = rx_valid; bit2 tx_drop, sticky; remaining bits 0.
REQ-012 SHALL use FSM states IDLE, SETUP, WAIT, ACCESS with these transitions:
- IDLE->SETUP on psel & ~penable.
- SETUP->WAIT if WAIT_STATES>0, else SETUP->ACCESS.
- WAIT->ACCESS once the wait counter reaches WAIT_STATES.
- ACCESS->IDLE, or ACCESS->SETUP on back-to-back psel & ~penable.
REQ-013 SHALL hold pready low in SETUP and WAIT, drive it high only in ACCESS, and keep it low in IDLE.
REQ-014 SHALL give a total access latency of 2+WAIT_STATES cycles from psel rising to the pready-high cycle.
REQ-015 SHALL commit a write only in the ACCESS cycle, and only when psel & penable & pwrite.
REQ-016 SHALL drive prdata with registered read data valid in the ACCESS cycle, and 0 in all other cycles.
REQ-017 SHALL, on a TXDATA write with tx_full=0, load tx_data and pulse tx_wr high for exactly that one cycle.
REQ-018 SHALL, on a TXDATA write with tx_full=1, not pulse tx_wr, leave tx_data unchanged, and set tx_drop.
REQ-019 SHALL, on an RXDATA read, return rx_data and pulse rx_rd for one cycle only if rx_valid=1; otherwise return 0 with no pulse.
REQ-020 SHALL clear tx_drop on a STATUS read, and keep it set if a drop occurs in the same cycle (set wins).
REQ-021 SHALL ignore writes to RO and reserved slots and return 0 on reads of reserved slots.
REQ-022 SHALL drive irq combinationally as (ctrl[0] & rx_valid) | (ctrl[1] & ~tx_full) | (ctrl[2] & tx_drop).
REQ-023 SHALL abandon the transfer and return to IDLE with no side effects if psel drops during SETUP or WAIT.

Reset
REQ-024 SHALL, while presetn=0, force: FSM IDLE; pready 0; pslverr 0; prdata 0; all RW registers 0; tx_data 0; tx_wr 0; rx_rd 0; tx_drop 0; wait counter 0.
REQ-025 SHALL abort any in-flight transfer on reset assertion mid-access, with no strobe emitted.
REQ-026 SHALL respond to the first SETUP cycle after reset release.

Configuration
REQ-027 SHALL, with APB_UART_REGFILE_PSLVERR_EN defined, assert pslverr in the ACCESS cycle for:
- any reserved-slot access;
- a write to an RO register;
- a TXDATA write with tx_full=1;
- a read of the WO TXDATA register.
REQ-028 SHALL, without APB_UART_REGFILE_PSLVERR_EN defined, tie pslverr to 0, with all other behaviour unchanged.

Structure
REQ-029 SHALL place the FSM state typedef, register offset constants, and STATUS bit indices in shared package apb_uart_pkg.
REQ-030 SHALL place the APB handshake FSM and wait counter in sub-module apb_uart_fsm, which outputs an access_en pulse and pready.

Verification
REQ-031 SHALL cover: WAIT_STATES=2, write 0x34 to slot 0 and 0x12 to slot 1 -> pready high in cycle 4 of each access, baud_val=0x1234.
REQ-032 SHALL cover: tx_full=0, write 0xA5 to slot 2 -> tx_data=0xA5, tx_wr high exactly 1 cycle.
REQ-033 SHALL cover: tx_full=1, write 0x5A to slot 2 -> no tx_wr, STATUS=0x04, then a second STATUS read returns bit2=0.
REQ-034 SHALL cover: rx_valid=1, rx_data=0x3C, read slot 3 -> prdata=0x3C and one rx_rd pulse; with rx_valid=0 -> prdata=0 and no pulse.
REQ-035 SHALL cover: presetn low during WAIT of a slot 5 write of 0xFF -> ctrl stays 0, FSM in IDLE, pready 0.
REQ-036 SHALL cover: with PSLVERR_EN defined, write to slot 7 -> pslverr=1 in the ACCESS cycle; without it -> pslverr=0, and a read of slot 7 returns 0.

Source files
------------

// File: rtl/apb_uart_pkg.sv
// Shared types and constants for the APB UART register file: handshake FSM states,
// register slot offsets and STATUS bit positions.
package apb_uart_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StWait,
      StAccess
   } apb_state_e;

   localparam int unsigned RegBaudLo = 0;
   localparam int unsigned RegBaudHi = 1;
   localparam int unsigned RegTxData = 2;
   localparam int unsigned RegRxData = 3;
   localparam int unsigned RegStatus = 4;
   localparam int unsigned RegCtrl   = 5;
   localparam int unsigned NumRegs   = 6;

   localparam int unsigned StatusTxRdy  = 0;
   localparam int unsigned StatusRxRdy  = 1;
   localparam int unsigned StatusTxDrop = 2;

   function automatic logic is_reserved(input logic [31:0] addr);
      return addr >= NumRegs;
   endfunction

endpackage

// File: rtl/apb_uart_fsm.sv
// APB slave handshake: IDLE/SETUP/WAIT/ACCESS sequencing with a programmable number of
// wait states, producing pready plus the read-load and access-commit qualifiers.
module apb_uart_fsm
   import apb_uart_pkg::*;
#(
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic pclk,
   input  logic presetn,
   input  logic psel,
   input  logic penable,
   output logic access_en,
   output logic rd_load,
   output logic pready
);

   apb_state_e state_q, state_d;
   logic [1:0] cnt_q, cnt_d, cnt_inc;

   assign cnt_inc = cnt_q + 2'd1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (psel && !penable) begin
               state_d = StSetup;
            end
         end
         StSetup: begin
            cnt_d = '0;
            if (!psel) begin
               state_d = StIdle;
            end else if (WAIT_STATES > 0) begin
               state_d = StWait;
            end else begin
               state_d = StAccess;
            end
         end
         StWait: begin
            if (!psel) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (32'(cnt_inc) == WAIT_STATES) begin
               state_d = StAccess;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         StAccess: begin
            cnt_d = '0;
            if (psel && !penable) begin
               state_d = StSetup;
            end else begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Read data is captured on the edge that enters ACCESS so it is stable for that cycle.
   assign rd_load   = (state_d == StAccess);
   assign pready    = (state_q == StAccess);
   assign access_en = (state_q == StAccess) && psel && penable;

endmodule

// File: rtl/apb_uart_regfile.sv
// APB register file for a UART: baud divisor, control, TX/RX data ports and sticky status.
// Optional error responses are enabled by defining APB_UART_REGFILE_PSLVERR_EN.
module apb_uart_regfile
   import apb_uart_pkg::*;
#(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned ADDR_W      = 3,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic                pclk,
   input  logic                presetn,
   input  logic                psel,
   input  logic                penable,
   input  logic                pwrite,
   input  logic [ADDR_W-1:0]   paddr,
   input  logic [DATA_W-1:0]   pwdata,
   output logic [DATA_W-1:0]   prdata,
   output logic                pready,
   output logic                pslverr,
   output logic [2*DATA_W-1:0] baud_val,
   output logic [DATA_W-1:0]   ctrl,
   output logic [DATA_W-1:0]   tx_data,
   output logic                tx_wr,
   input  logic                tx_full,
   input  logic [DATA_W-1:0]   rx_data,
   input  logic                rx_valid,
   output logic                rx_rd,
   output logic                irq
);

   logic              access_en;
   logic              rd_load;
   logic              write_en;
   logic              read_load;
   logic [31:0]       addr;
   logic              tx_push;
   logic              tx_drop_set;
   logic              rx_pop;
   logic              status_rd;
   logic [DATA_W-1:0] status;
   logic [DATA_W-1:0] rd_mux;

   logic [DATA_W-1:0] baud_lo_q, baud_hi_q, ctrl_q, tx_data_q, prdata_q;
   logic              tx_wr_q, rx_rd_q, tx_drop_q;

   apb_uart_fsm #(
      .WAIT_STATES (WAIT_STATES)
   ) u_fsm (
      .pclk      (pclk),
      .presetn   (presetn),
      .psel      (psel),
      .penable   (penable),
      .access_en (access_en),
      .rd_load   (rd_load),
      .pready    (pready)
   );

   assign addr      = 32'(paddr);
   assign write_en  = access_en & pwrite;
   assign read_load = rd_load & ~pwrite;

   assign tx_push     = write_en & (addr == RegTxData) & ~tx_full;
   assign tx_drop_set = write_en & (addr == RegTxData) & tx_full;
   assign rx_pop      = read_load & (addr == RegRxData) & rx_valid;
   assign status_rd   = read_load & (addr == RegStatus);

   always_comb begin
      status               = '0;
      status[StatusTxRdy]  = ~tx_full;
      status[StatusRxRdy]  = rx_valid;
      status[StatusTxDrop] = tx_drop_q;
   end

   // TXDATA is write-only and reserved slots read as zero.
   always_comb begin
      rd_mux = '0;
      case (addr)
         RegBaudLo: rd_mux = baud_lo_q;
         RegBaudHi: rd_mux = baud_hi_q;
         RegRxData: rd_mux = rx_valid ? rx_data : '0;
         RegStatus: rd_mux = status;
         RegCtrl:   rd_mux = ctrl_q;
         default:   rd_mux = '0;
      endcase
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         baud_lo_q <= '0;
         baud_hi_q <= '0;
         ctrl_q    <= '0;
         tx_data_q <= '0;
         prdata_q  <= '0;
         tx_wr_q   <= 1'b0;
         rx_rd_q   <= 1'b0;
         tx_drop_q <= 1'b0;
      end else begin
         tx_wr_q  <= tx_push;
         rx_rd_q  <= rx_pop;
         prdata_q <= read_load ? rd_mux : '0;
         if (tx_push) begin
            tx_data_q <= pwdata;
         end
         if (write_en) begin
            case (addr)
               RegBaudLo: baud_lo_q <= pwdata;
               RegBaudHi: baud_hi_q <= pwdata;
               RegCtrl:   ctrl_q    <= pwdata;
               default:   ;
            endcase
         end
         // A drop landing with a STATUS read keeps the flag set.
         if (tx_drop_set) begin
            tx_drop_q <= 1'b1;
         end else if (status_rd) begin
            tx_drop_q <= 1'b0;
         end
      end
   end

`ifdef APB_UART_REGFILE_PSLVERR_EN
   logic err_cond;
   assign err_cond = is_reserved(addr)
                   | (pwrite & ((addr == RegRxData) | (addr == RegStatus)))
                   | (pwrite & (addr == RegTxData) & tx_full)
                   | (~pwrite & (addr == RegTxData));
   assign pslverr  = access_en & err_cond;
`else
   assign pslverr  = 1'b0;
`endif

   assign prdata   = prdata_q;
   assign baud_val = {baud_hi_q, baud_lo_q};
   assign ctrl     = ctrl_q;
   assign tx_data  = tx_data_q;
   assign tx_wr    = tx_wr_q;
   assign rx_rd    = rx_rd_q;
   assign irq      = (ctrl_q[0] & rx_valid) | (ctrl_q[1] & ~tx_full) | (ctrl_q[2] & tx_drop_q);

endmodule
